// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, prot default and the control
// master FSM state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRITE_RESP,
    ST_READ_ADDR,
    ST_READ_DATA,
    ST_RESPOND
  } state_t;

endpackage

// File: rtl/axi4_lite_watchdog.sv
// Per-state cycle counter for the control master; expired fires once the FSM
// has waited TIMEOUT_CYCLES in a single bus-waiting state.
module axi4_lite_watchdog
  import axi4_lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic   clk,
  input  logic   rst_n,
  input  state_t state,
  output logic   expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  state_t        prev;
  logic          run;
  logic          entered;

  assign run     = state inside {ST_WRITE, ST_WRITE_RESP, ST_READ_ADDR, ST_READ_DATA};
  assign entered = (state != prev);
  assign expired = run && !entered && (cnt == CW'(TIMEOUT_CYCLES));

  // The first cycle in a new state counts as one, so the count restarts per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      prev <= ST_IDLE;
    end else begin
      prev <= state;
      if (!run)                           cnt <= '0;
      else if (entered)                   cnt <= CW'(1);
      else if (cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axi4_lite_ctrl_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one response out.
// Optional watchdog recovery is enabled by defining AXI4_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_ctrl_master
  import axi4_lite_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                          m_axi_ctrl_aclk,
  input  logic                          m_axi_ctrl_aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic [AXI_ADDRESS_WIDTH-1:0]  m_axi_ctrl_awaddr,
  output logic [2:0]                    m_axi_ctrl_awprot,
  output logic                          m_axi_ctrl_awvalid,
  input  logic                          m_axi_ctrl_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_ctrl_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_ctrl_wstrb,
  output logic                          m_axi_ctrl_wvalid,
  input  logic                          m_axi_ctrl_wready,
  input  logic [1:0]                    m_axi_ctrl_bresp,
  input  logic                          m_axi_ctrl_bvalid,
  output logic                          m_axi_ctrl_bready,
  output logic [AXI_ADDRESS_WIDTH-1:0]  m_axi_ctrl_araddr,
  output logic [2:0]                    m_axi_ctrl_arprot,
  output logic                          m_axi_ctrl_arvalid,
  input  logic                          m_axi_ctrl_arready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_ctrl_rdata,
  input  logic [1:0]                    m_axi_ctrl_rresp,
  input  logic                          m_axi_ctrl_rvalid,
  output logic                          m_axi_ctrl_rready
);

  if (!(AXI_DATA_WIDTH == 32 || AXI_DATA_WIDTH == 64) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("axi4_lite_ctrl_master: AXI_DATA_WIDTH must be 32 or 64, TIMEOUT_CYCLES >= 1");
  end

  state_t state;
  logic   aw_done, w_done;
  logic   aw_hs, w_hs;

  assign m_axi_ctrl_awprot = PROT_DEFAULT;
  assign m_axi_ctrl_arprot = PROT_DEFAULT;
  assign aw_hs = m_axi_ctrl_awvalid && m_axi_ctrl_awready;
  assign w_hs  = m_axi_ctrl_wvalid && m_axi_ctrl_wready;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  logic wd_expired;

  axi4_lite_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (m_axi_ctrl_aclk),
    .rst_n   (m_axi_ctrl_aresetn),
    .state   (state),
    .expired (wd_expired)
  );
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge m_axi_ctrl_aclk or negedge m_axi_ctrl_aresetn) begin
    if (!m_axi_ctrl_aresetn) begin
      state              <= ST_IDLE;
      cmd_ready          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= '0;
      rsp_resp           <= RESP_OKAY;
      aw_done            <= 1'b0;
      w_done             <= 1'b0;
      m_axi_ctrl_awaddr  <= '0;
      m_axi_ctrl_awvalid <= 1'b0;
      m_axi_ctrl_wdata   <= '0;
      m_axi_ctrl_wstrb   <= '0;
      m_axi_ctrl_wvalid  <= 1'b0;
      m_axi_ctrl_bready  <= 1'b0;
      m_axi_ctrl_araddr  <= '0;
      m_axi_ctrl_arvalid <= 1'b0;
      m_axi_ctrl_rready  <= 1'b0;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      rsp_timeout        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // cmd_ready is registered, so it first rises one edge after reset release.
          if (cmd_ready && cmd_valid) begin
            cmd_ready          <= 1'b0;
            m_axi_ctrl_awaddr  <= cmd_addr;
            m_axi_ctrl_araddr  <= cmd_addr;
            m_axi_ctrl_wdata   <= cmd_wdata;
            m_axi_ctrl_wstrb   <= cmd_wstrb;
            if (cmd_write) begin
              state              <= ST_WRITE;
              m_axi_ctrl_awvalid <= 1'b1;
              m_axi_ctrl_wvalid  <= 1'b1;
            end else begin
              state              <= ST_READ_ADDR;
              m_axi_ctrl_arvalid <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (aw_hs) begin
            m_axi_ctrl_awvalid <= 1'b0;
            aw_done            <= 1'b1;
          end
          if (w_hs) begin
            m_axi_ctrl_wvalid <= 1'b0;
            w_done            <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state             <= ST_WRITE_RESP;
            m_axi_ctrl_bready <= 1'b1;
          end
        end
        ST_WRITE_RESP: begin
          if (m_axi_ctrl_bvalid && m_axi_ctrl_bready) begin
            m_axi_ctrl_bready <= 1'b0;
            rsp_resp          <= m_axi_ctrl_bresp;
            rsp_rdata         <= '0;
            rsp_valid         <= 1'b1;
            state             <= ST_RESPOND;
          end
        end
        ST_READ_ADDR: begin
          if (m_axi_ctrl_arvalid && m_axi_ctrl_arready) begin
            m_axi_ctrl_arvalid <= 1'b0;
            m_axi_ctrl_rready  <= 1'b1;
            state              <= ST_READ_DATA;
          end
        end
        ST_READ_DATA: begin
          if (m_axi_ctrl_rvalid && m_axi_ctrl_rready) begin
            m_axi_ctrl_rready <= 1'b0;
            rsp_resp          <= m_axi_ctrl_rresp;
            rsp_rdata         <= m_axi_ctrl_rdata;
            rsp_valid         <= 1'b1;
            state             <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      if (state == ST_IDLE && cmd_ready && cmd_valid) rsp_timeout <= 1'b0;
      // Abandon the bus mid-transfer; the fabric must be reset afterwards.
      if (wd_expired) begin
        m_axi_ctrl_awvalid <= 1'b0;
        m_axi_ctrl_wvalid  <= 1'b0;
        m_axi_ctrl_bready  <= 1'b0;
        m_axi_ctrl_arvalid <= 1'b0;
        m_axi_ctrl_rready  <= 1'b0;
        rsp_resp           <= RESP_SLVERR;
        rsp_rdata          <= '0;
        rsp_timeout        <= 1'b1;
        rsp_valid          <= 1'b1;
        state              <= ST_RESPOND;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4_lite_ctrl_master.sv
// Randomized bench for axi4_lite_ctrl_master: an in-bench memory slave with
// programmable latencies, and a reference memory/latency model for expectations.
module tb_axi4_lite_ctrl_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axi4_lite_ctrl_master #(
    .AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .m_axi_ctrl_aclk(clk), .m_axi_ctrl_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_ctrl_awaddr(awaddr), .m_axi_ctrl_awprot(awprot),
    .m_axi_ctrl_awvalid(awvalid), .m_axi_ctrl_awready(awready),
    .m_axi_ctrl_wdata(wdata), .m_axi_ctrl_wstrb(wstrb),
    .m_axi_ctrl_wvalid(wvalid), .m_axi_ctrl_wready(wready),
    .m_axi_ctrl_bresp(bresp), .m_axi_ctrl_bvalid(bvalid), .m_axi_ctrl_bready(bready),
    .m_axi_ctrl_araddr(araddr), .m_axi_ctrl_arprot(arprot),
    .m_axi_ctrl_arvalid(arvalid), .m_axi_ctrl_arready(arready),
    .m_axi_ctrl_rdata(rdata), .m_axi_ctrl_rresp(rresp),
    .m_axi_ctrl_rvalid(rvalid), .m_axi_ctrl_rready(rready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int gcyc = 0, last_hs = 0, hs_gap = 0;
  int aw_lat, w_lat, b_lat, ar_lat, r_lat, rsp_lat;
  logic [1:0] bresp_v, rresp_v;
  bit exp_to = 1'b0;
  logic [31:0] smem [16];   // slave-side storage, written only through the bus
  logic [31:0] ref_mem [16]; // reference model, written from commands

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    gcyc++;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic slave_idle();
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rsp_ready = 0;
  endtask

  // One command from request to response, acting as requester and slave at each negedge.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input bit abort);
    int n = 0, c0 = -1, rsp_first = -1, exp_lat;
    int awc = 0, wc = 0, bc = 0, arc = 0, rc = 0, rspc = 0;
    bit aw_got = 0, w_got = 0, b_got = 0, ar_got = 0, r_got = 0, mem_wr = 0;
    bit done = 0, aborted = 0, hs_now, bad_ch = 0;
    logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0, h_rdata = 0, exp_rdata;
    logic [3:0]  s_wstrb = 0;
    logic [1:0]  h_resp = 0, exp_resp;
    logic        h_to = 0;
    if (wr) begin
      exp_rdata = 32'h0;
      exp_resp  = bresp_v;
      exp_lat   = ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat + 3;
      ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], data, strb);
    end else begin
      exp_rdata = ref_mem[addr[5:2]];
      exp_resp  = rresp_v;
      exp_lat   = ar_lat + r_lat + 3;
    end
    if (exp_to) begin exp_rdata = 32'h0; exp_resp = 2'b10; end
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    while (!done && n < 300) begin
      awready = awvalid && !aw_got && (awc >= aw_lat);
      if (awvalid && !awready) awc++;
      wready = wvalid && !w_got && (wc >= w_lat);
      if (wvalid && !wready) wc++;
      bvalid = aw_got && w_got && !b_got && (bc >= b_lat);
      if (aw_got && w_got && !b_got && !bvalid) bc++;
      bresp = bvalid ? bresp_v : 2'b00;
      arready = arvalid && !ar_got && (arc >= ar_lat);
      if (arvalid && !arready) arc++;
      rvalid = ar_got && !r_got && (rc >= r_lat);
      if (ar_got && !r_got && !rvalid) rc++;
      rdata = rvalid ? smem[s_araddr[5:2]] : 32'h0;
      rresp = rvalid ? rresp_v : 2'b00;
      rsp_ready = rsp_valid && (rspc >= rsp_lat);
      if (rsp_valid && !rsp_ready) rspc++;
      if (abort && rready) begin
        rst_n = 0;
        cmd_valid = 0;
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        slave_idle();
        step(); step();
        rst_n = 1;
        #1 chk("rel_cmd_ready_pre", cmd_ready, 0);
        step();
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_rsp_valid", rsp_valid, 0);
        aborted = 1;
        break;
      end
      if (!wr && (awvalid || wvalid || bready)) bad_ch = 1;
      if (wr && (arvalid || rready)) bad_ch = 1;
      hs_now = cmd_valid && cmd_ready;
      if (hs_now) begin
        c0 = n;
        hs_gap = gcyc - last_hs;
        last_hs = gcyc;
      end
      if (awvalid && awready) begin
        aw_got = 1; s_awaddr = awaddr;
        chk("aw_addr", awaddr, addr);
        chk("aw_cycle", n - c0, aw_lat + 1);
      end
      if (wvalid && wready) begin
        w_got = 1; s_wdata = wdata; s_wstrb = wstrb;
        chk("w_data", wdata, data);
        chk("w_strb", wstrb, strb);
        chk("w_cycle", n - c0, w_lat + 1);
      end
      if (aw_got && w_got && !mem_wr) begin
        smem[s_awaddr[5:2]] = merge(smem[s_awaddr[5:2]], s_wdata, s_wstrb);
        mem_wr = 1;
      end
      if (bvalid && bready) b_got = 1;
      if (arvalid && arready) begin
        ar_got = 1; s_araddr = araddr;
        chk("ar_addr", araddr, addr);
      end
      if (rvalid && rready) r_got = 1;
      if (rsp_valid) begin
        if (rsp_first < 0) begin
          rsp_first = n; h_rdata = rsp_rdata; h_resp = rsp_resp; h_to = rsp_timeout;
          chk("rsp_rdata", rsp_rdata, exp_rdata);
          chk("rsp_resp", rsp_resp, exp_resp);
          chk("rsp_timeout", rsp_timeout, exp_to);
          if (exp_to) begin
            chk("to_bready", bready, 0);
            chk("to_latency_ok", (n - c0 >= 18) && (n - c0 <= 21), 1);
          end else begin
            chk("rsp_latency", n - c0, exp_lat);
          end
        end else begin
          chk("hold_rdata", rsp_rdata, h_rdata);
          chk("hold_resp", rsp_resp, h_resp);
          chk("hold_to", rsp_timeout, h_to);
          chk("hold_cmd_ready", cmd_ready, 0);
          chk("hold_quiet", {awvalid, wvalid, bready, arvalid, rready}, 0);
        end
        if (rsp_ready) done = 1;
      end
      step();
      if (hs_now) cmd_valid = 0;
      n++;
    end
    if (!aborted) begin
      chk("txn_done", done, 1);
      chk("wrong_channel", bad_ch, 0);
    end
    slave_idle();
  endtask

  task automatic zero_lat();
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0; rsp_lat = 0;
    bresp_v = 2'b00; rresp_v = 2'b00;
  endtask

  initial begin
    logic [31:0] a, d;
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    slave_idle();
    for (int i = 0; i < 16; i++) begin
      smem[i] = $urandom;
      ref_mem[i] = smem[i];
    end
    step(); step(); step();
    chk("reset_outputs", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_timeout}, 0);
    chk("reset_data", {awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, awprot, arprot}, 0);
    rst_n = 1;
    #1 chk("cmd_ready_pre_edge", cmd_ready, 0);
    step();
    chk("cmd_ready_post_edge", cmd_ready, 1);

    // Directed write with slow awready and immediate wready.
    zero_lat(); aw_lat = 3;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);

    // Read returning SLVERR passes the code and data through.
    zero_lat(); rresp_v = 2'b10;
    smem[9] = 32'h12345678; ref_mem[9] = 32'h12345678;
    txn(1'b0, 32'h24, 32'h0, 4'h0, 1'b0);

    // Requester stalls the response for five cycles.
    zero_lat(); rsp_lat = 5;
    txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

    // Back-to-back write then read of the same word.
    zero_lat();
    txn(1'b1, 32'h4, 32'hA5A5_1234, 4'hF, 1'b0);
    txn(1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    chk("b2b_period", hs_gap, 4);

    // Randomized traffic with random latencies, strobes and responses.
    for (int i = 0; i < 40; i++) begin
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3); rsp_lat = $urandom_range(0, 2);
      bresp_v = 2'($urandom_range(0, 3)); rresp_v = 2'($urandom_range(0, 3));
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      txn(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), 1'b0);
    end

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    // Slave never answers on B; the watchdog produces the response.
    zero_lat(); b_lat = 1000; exp_to = 1'b1;
    txn(1'b1, 32'h8, 32'h0BAD_F00D, 4'hF, 1'b0);
    exp_to = 1'b0;
`endif

    // Reset asserted while waiting for read data.
    zero_lat(); r_lat = 50;
    txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);

    // Block recovers and serves a normal read afterwards.
    zero_lat();
    txn(1'b0, 32'h4, 32'h0, 4'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
